// File: rtl/uart_word_loader.sv
// uart_word_loader
//
// Packs pairs of UART bytes (low byte first) into 16-bit words and writes
// them to consecutive memory word addresses starting at 0, using a simple
// req/ack handshake. One extra byte may be buffered while a write is in
// progress; any byte beyond that is dropped and flagged as an overrun.
//
// Optional feature: define LOADER_CHECKSUM_EN to accumulate a running XOR
// of all written words on the checksum port. Without it checksum is tied 0.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   load_en     load mode enable; dropping it discards any held low byte
//   byte_data   received byte, valid while byte_ready is high
//   byte_ready  receiver level; each 0->1 transition is one new byte
//   mem_req     write request, held until mem_ack is sampled high
//   mem_addr    word address of the current write
//   mem_wdata   word being written ({high, low})
//   mem_ack     write accepted (ignored while mem_req is low)
//   word_count  number of completed writes (wraps)
//   first_byte  a low byte is held and its high byte is awaited
//   overrun     sticky: a byte was dropped
//   checksum    running XOR of written words (0 without LOADER_CHECKSUM_EN)
module uart_word_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [7:0]        byte_data,
  input  logic              byte_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] word_count,
  output logic              first_byte,
  output logic              overrun,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {S_LO, S_HI, S_WR} state_t;

  state_t              state_reg, state_next;
  logic                ready_reg;
  logic [7:0]          low_reg, low_next;
  logic                first_reg, first_next;
  logic                overrun_reg, overrun_next;
  logic                req_reg, req_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [15:0]         wdata_reg, wdata_next;
  logic [ADDR_W-1:0]   count_reg, count_next;

  logic byte_event;
  logic ack;

  assign byte_event = load_en & byte_ready & ~ready_reg;
  // req_reg is high exactly while in S_WR, so this also gates stray acks.
  assign ack = req_reg & mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_LO;
      ready_reg   <= 1'b0;
      low_reg     <= '0;
      first_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      req_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= byte_ready;
      low_reg     <= low_next;
      first_reg   <= first_next;
      overrun_reg <= overrun_next;
      req_reg     <= req_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    low_next     = low_reg;
    first_next   = first_reg;
    overrun_next = overrun_reg;
    req_next     = req_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    count_next   = count_reg;

    case (state_reg)
      S_LO: begin
        if (byte_event) begin
          low_next   = byte_data;
          first_next = 1'b1;
          state_next = S_HI;
        end
      end

      S_HI: begin
        if (!load_en) begin
          // Leaving load mode throws away the half-assembled word.
          first_next = 1'b0;
          state_next = S_LO;
        end else if (byte_event) begin
          wdata_next = {byte_data, low_reg};
          addr_next  = count_reg;
          req_next   = 1'b1;
          first_next = 1'b0;
          state_next = S_WR;
        end
      end

      S_WR: begin
        // low_reg is free here (the word is already in wdata_reg), so it
        // doubles as the one-deep pending-byte buffer.
        if (byte_event) begin
          if (first_reg) begin
            overrun_next = 1'b1;
          end else begin
            low_next   = byte_data;
            first_next = 1'b1;
          end
        end
        if (!load_en) begin
          first_next = 1'b0;
        end
        // Uses first_next so a byte arriving in the ack cycle is honoured.
        if (ack) begin
          req_next   = 1'b0;
          count_next = count_reg + ADDR_W'(1);
          state_next = first_next ? S_HI : S_LO;
        end
      end

      default: begin
        state_next = S_LO;
      end
    endcase
  end

  assign mem_req    = req_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign word_count = count_reg;
  assign first_byte = first_reg;
  assign overrun    = overrun_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (ack) begin
      checksum_reg <= checksum_reg ^ wdata_reg;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'h0000;
`endif

endmodule
